// File: rtl/i2s_stream_tx.sv
// Buffered I2S transmitter: valid/ready sample FIFO feeding a frame-locked serializer.
// One stereo pair is popped per LRCK frame and sent MSB-first with the one-slot I2S delay.
module i2s_stream_tx #(
  parameter int DEPTH     = 4,
  parameter int DIV_BITS  = 9,
  parameter bit HOLD_LAST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              in_left,
  input  logic [15:0]              in_right,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  output logic [7:0]               underrun_cnt,
  output logic                     audio_mclk,
  output logic                     audio_lrck,
  output logic                     audio_sck,
  output logic                     audio_sdin
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [DIV_BITS-1:0] cnt;
  logic [31:0]         mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [15:0]         left_word;
  logic [15:0]         right_word;
  logic                rlsb;
  logic                push;
  logic                load;
  logic                pop;
  logic [4:0]          slot;
  logic [3:0]          bit_idx;

  // Readiness comes only from registered occupancy, so a full FIFO refuses a
  // push even in the cycle that the frame load frees an entry.
  assign in_ready = (level != FULL_LEVEL);
  assign push     = in_valid & in_ready;
  assign load     = &cnt;
  assign pop      = load & (level != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_left, in_right};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A word pushed on the load edge into an empty FIFO is not popped: the
  // frame underruns and that word waits for the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_word    <= '0;
      right_word   <= '0;
      rlsb         <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      if (load) begin
        rlsb <= right_word[0];
        if (pop) begin
          {left_word, right_word} <= mem[rd_ptr];
        end else begin
          if (!HOLD_LAST) begin
            left_word  <= '0;
            right_word <= '0;
          end
          underrun <= 1'b1;
          if (underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Slot s carries L[16-s] or R[32-s]; both reduce to bit (-s) mod 16.
  assign slot    = cnt[DIV_BITS-1 -: 5];
  assign bit_idx = 4'd0 - slot[3:0];

  always_comb begin
    audio_sdin = rlsb;
    if (slot == 5'd0) begin
      audio_sdin = rlsb;
    end else if (slot <= 5'd16) begin
      audio_sdin = left_word[bit_idx];
    end else begin
      audio_sdin = right_word[bit_idx];
    end
  end

  assign audio_mclk = cnt[1];
  assign audio_lrck = cnt[DIV_BITS-1];
  assign audio_sck  = 1'b1;

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Bench for i2s_stream_tx: two instances (zero-fill at 512-clk frames, hold-last at 128-clk
// frames) compared every cycle against a frame-level sample-queue model.
module tb_i2s_stream_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, valid_a = 1'b0;
  logic [15:0] left_a = '0, right_a = '0;
  logic        in_ready_a, underrun_a, mclk_a, lrck_a, sck_a, sdin_a;
  logic [2:0]  level_a;
  logic [7:0]  underrun_cnt_a;

  logic        rst_b = 1'b0, valid_b = 1'b0;
  logic [15:0] left_b = '0, right_b = '0;
  logic        in_ready_b, underrun_b, mclk_b, lrck_b, sck_b, sdin_b;
  logic [2:0]  level_b;
  logic [7:0]  underrun_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  i2s_stream_tx #(.DEPTH(4), .DIV_BITS(9), .HOLD_LAST(1'b0)) dut_a (
    .clk(clk), .rst(rst_a), .in_left(left_a), .in_right(right_a), .in_valid(valid_a),
    .in_ready(in_ready_a), .level(level_a), .underrun(underrun_a), .underrun_cnt(underrun_cnt_a),
    .audio_mclk(mclk_a), .audio_lrck(lrck_a), .audio_sck(sck_a), .audio_sdin(sdin_a));

  i2s_stream_tx #(.DEPTH(4), .DIV_BITS(7), .HOLD_LAST(1'b1)) dut_b (
    .clk(clk), .rst(rst_b), .in_left(left_b), .in_right(right_b), .in_valid(valid_b),
    .in_ready(in_ready_b), .level(level_b), .underrun(underrun_b), .underrun_cnt(underrun_cnt_b),
    .audio_mclk(mclk_b), .audio_lrck(lrck_b), .audio_sck(sck_b), .audio_sdin(sdin_b));

  // Reference: queue of pending pairs, the pair now playing, and the clock count since reset.
  typedef struct {
    logic [31:0] q[4];
    int          n;
    logic [15:0] l;
    logic [15:0] r;
    logic        rlsb;
    int          ucnt;
    logic        upulse;
    int          cyc;
  } model_t;

  model_t ma, mb;
  logic [31:0] cap_a, cap_b;
  int pulses_a, ones_a, lrck_rise_a;
  bit lrck_seen_a;

  function automatic model_t resetModel();
    model_t m;
    for (int i = 0; i < 4; i++) m.q[i] = '0;
    m.n = 0; m.l = '0; m.r = '0; m.rlsb = 1'b0;
    m.ucnt = 0; m.upulse = 1'b0; m.cyc = 0;
    return m;
  endfunction

  function automatic model_t step(input model_t m, input bit v, input logic [31:0] d,
                                  input int frame, input bit hold);
    model_t x = m;
    bit ready = (m.n < 4);
    x.upulse = 1'b0;
    if ((m.cyc % frame) == frame - 1) begin
      x.rlsb = m.r[0];
      if (m.n > 0) begin
        {x.l, x.r} = m.q[0];
        for (int i = 0; i < 3; i++) x.q[i] = x.q[i+1];
        x.n = x.n - 1;
      end else begin
        if (!hold) begin
          x.l = '0;
          x.r = '0;
        end
        x.upulse = 1'b1;
        if (x.ucnt < 255) x.ucnt = x.ucnt + 1;
      end
    end
    if (v && ready) begin
      x.q[x.n] = d;
      x.n = x.n + 1;
    end
    x.cyc = m.cyc + 1;
    return x;
  endfunction

  function automatic logic [31:0] expOuts(input model_t m, input int frame);
    int c = m.cyc % frame;
    int s = c / (frame / 32);
    logic sd;
    if (s == 0) sd = m.rlsb;
    else if (s <= 16) sd = m.l[16-s];
    else sd = m.r[32-s];
    return {15'd0, (m.n < 4), 3'(m.n), m.upulse, 8'(m.ucnt),
            1'(((c / 2) % 2) != 0), (c >= frame / 2), 1'b1, sd};
  endfunction

  function automatic logic [31:0] outsA();
    return {15'd0, in_ready_a, level_a, underrun_a, underrun_cnt_a, mclk_a, lrck_a, sck_a, sdin_a};
  endfunction

  function automatic logic [31:0] outsB();
    return {15'd0, in_ready_b, level_b, underrun_b, underrun_cnt_b, mclk_b, lrck_b, sck_b, sdin_b};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called right after a falling edge: drive inputs for the next rising edge, then check.
  task automatic applyStimulusA(input bit v, input logic [31:0] d);
    int c;
    valid_a = v; left_a = d[31:16]; right_a = d[15:0];
    ma = step(ma, v, d, 512, 1'b0);
    @(negedge clk);
    checkOutput("A.outs", outsA(), expOuts(ma, 512));
    c = ma.cyc % 512;
    if (c % 16 == 8) cap_a[31 - c/16] = sdin_a;
    if (underrun_a) pulses_a++;
    if (sdin_a) ones_a++;
    if (lrck_a && !lrck_seen_a) begin
      lrck_seen_a = 1'b1;
      lrck_rise_a = ma.cyc;
    end
  endtask

  task automatic applyStimulusB(input bit v, input logic [31:0] d);
    int c;
    valid_b = v; left_b = d[31:16]; right_b = d[15:0];
    mb = step(mb, v, d, 128, 1'b1);
    @(negedge clk);
    checkOutput("B.outs", outsB(), expOuts(mb, 128));
    c = mb.cyc % 128;
    if (c % 4 == 2) cap_b[31 - c/4] = sdin_b;
  endtask

  task automatic resetA();
    rst_a = 1'b1; valid_a = 1'b0;
    #1;
    checkOutput("A.rst_async", outsA(), expOuts(resetModel(), 512));
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    ma = resetModel();
    lrck_seen_a = 1'b0; lrck_rise_a = -1; pulses_a = 0; ones_a = 0;
    checkOutput("A.rst_level", 32'(level_a), 32'd0);
    checkOutput("A.rst_ready", 32'(in_ready_a), 32'd1);
  endtask

  task automatic idleUntilCntA(input int target);
    while ((ma.cyc % 512) != target) applyStimulusA(1'b0, '0);
  endtask

  task automatic procA();
    logic [31:0] burst [5];
    int k, thr;
    resetA();
    repeat (1540) applyStimulusA(1'b0, '0);
    checkOutput("A.lrck_first_rise", 32'(lrck_rise_a), 32'd256);
    checkOutput("A.underrun_pulses", 32'(pulses_a), 32'd3);
    checkOutput("A.underrun_cnt3", 32'(underrun_cnt_a), 32'd3);
    checkOutput("A.sdin_idle_ones", 32'(ones_a), 32'd0);

    resetA();
    repeat (3) applyStimulusA(1'b0, '0);
    applyStimulusA(1'b1, 32'hA5C3_5A3C);
    while (ma.cyc < 511) applyStimulusA(1'b0, '0);
    checkOutput("A.level_before_load", 32'(level_a), 32'd1);
    applyStimulusA(1'b0, '0);
    checkOutput("A.level_after_load", 32'(level_a), 32'd0);
    while (ma.cyc < 1024) applyStimulusA(1'b0, '0);
    checkOutput("A.frame2_left", 32'(cap_a[30:15]), 32'h0000_A5C3);
    checkOutput("A.frame2_right", 32'(cap_a[14:0]), 32'h0000_2D1E);
    checkOutput("A.frame2_slot0", 32'(cap_a[31]), 32'd0);
    while (ma.cyc < 1032) applyStimulusA(1'b0, '0);
    checkOutput("A.r0_next_frame", 32'(sdin_a), 32'd0);

    idleUntilCntA(511);
    applyStimulusA(1'b1, 32'h1234_8765);
    checkOutput("A.boundary_underrun", 32'(underrun_a), 32'd1);
    checkOutput("A.boundary_level", 32'(level_a), 32'd1);
    repeat (512) applyStimulusA(1'b0, '0);
    checkOutput("A.boundary_no_underrun", 32'(underrun_a), 32'd0);
    checkOutput("A.boundary_popped", 32'(level_a), 32'd0);

    idleUntilCntA(20);
    for (int i = 0; i < 5; i++) burst[i] = $urandom;
    for (int i = 0; i < 4; i++) applyStimulusA(1'b1, burst[i]);
    checkOutput("A.full_ready", 32'(in_ready_a), 32'd0);
    checkOutput("A.full_level", 32'(level_a), 32'd4);
    k = 0;
    do begin
      applyStimulusA(1'b1, burst[4]);
      k++;
    end while (!in_ready_a && k < 600);
    checkOutput("A.ready_rise_cnt", in_ready_a ? 32'(ma.cyc % 512) : 32'hFFFF_FFFF, 32'd0);
    applyStimulusA(1'b1, burst[4]);
    checkOutput("A.refill_level", 32'(level_a), 32'd4);

    thr = 1;
    for (int i = 0; i < 12 * 512; i++) begin
      if (i % 512 == 0) begin
        case ($urandom_range(0, 3))
          0: thr = 0;
          1: thr = 1;
          2: thr = 3;
          default: thr = 40;
        endcase
      end
      applyStimulusA($urandom_range(0, 511) < thr, $urandom);
    end

    repeat (5 * 512) applyStimulusA(1'b0, '0);
    idleUntilCntA(20);
    for (int i = 0; i < 3; i++) applyStimulusA(1'b1, $urandom);
    idleUntilCntA(200);
    checkOutput("A.level_before_rst", 32'(level_a), 32'd3);
    resetA();
    repeat (300) applyStimulusA(1'b0, '0);
    checkOutput("A.lrck_rise_after_rst", 32'(lrck_rise_a), 32'd256);
  endtask

  task automatic procB();
    rst_b = 1'b1; valid_b = 1'b0;
    #1;
    checkOutput("B.rst_async", outsB(), expOuts(resetModel(), 128));
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    mb = resetModel();
    repeat (5) applyStimulusB(1'b0, '0);
    applyStimulusB(1'b1, 32'hBEEF_0601);
    while (mb.cyc < 5 * 128 + 2) applyStimulusB(1'b0, '0);
    checkOutput("B.ucnt_5frames", 32'(underrun_cnt_b), 32'd4);
    while (mb.cyc < 11 * 128) applyStimulusB(1'b0, '0);
    checkOutput("B.hold_left", 32'(cap_b[30:15]), 32'h0000_BEEF);
    checkOutput("B.hold_right", 32'(cap_b[14:0]), 32'h0000_0300);
    checkOutput("B.hold_rlsb", 32'(cap_b[31]), 32'd1);
    while (mb.cyc < 305 * 128) applyStimulusB(1'b0, '0);
    checkOutput("B.ucnt_saturated", 32'(underrun_cnt_b), 32'd255);
  endtask

  initial begin
    @(negedge clk);
    fork
      procA();
      procB();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
